// File: rtl/ip_cpu_mem_bridge_pkg.sv
// rtl/ip_cpu_mem_bridge_pkg.sv - shared types and helpers for the CPU memory bridge
package ip_cpu_mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } bridgeState_t;

  // Error responses fill the read data with this bit value.
  localparam logic ERR_DATA_ONES = 1'b1;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/ip_cpu_mem_bridge.sv
// rtl/ip_cpu_mem_bridge.sv - host request to cpuMemReq/cpuMemAck bridge with gap and timeout
module ip_cpu_mem_bridge
  import ip_cpu_mem_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 64,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clockCore,
  input  logic                  resetCore,
  input  logic                  hostReqValid,
  output logic                  hostReqReady,
  input  logic                  hostReqRd,
  input  logic [ADDR_WIDTH-1:0] hostReqAddr,
  input  logic [DATA_WIDTH-1:0] hostReqWrData,
  output logic                  hostRspValid,
  input  logic                  hostRspReady,
  output logic [DATA_WIDTH-1:0] hostRspRdData,
  output logic                  hostRspErr,
  output logic                  cpuMemReq,
  output logic                  cpuMemRd,
  output logic [ADDR_WIDTH-1:0] cpuMemAddr,
  output logic [DATA_WIDTH-1:0] cpuMemWrData,
  input  logic                  cpuMemAck,
  input  logic [DATA_WIDTH-1:0] cpuMemRdData,
  output logic [7:0]            timeoutCnt
);

  localparam int TimerWidth = clog2(TIMEOUT);
  localparam int GapWidth   = clog2(GAP_CYCLES + 1);
  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TIMEOUT - 1);
  localparam logic [GapWidth-1:0]   GapLoad   = GapWidth'(GAP_CYCLES);

  bridgeState_t          state;
  logic [TimerWidth-1:0] waitTimer;
  logic [GapWidth-1:0]   gapCnt;

  assign hostReqReady = (state == IDLE) && (gapCnt == '0);

  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      state         <= IDLE;
      waitTimer     <= '0;
      gapCnt        <= '0;
      hostRspValid  <= 1'b0;
      hostRspRdData <= '0;
      hostRspErr    <= 1'b0;
      cpuMemReq     <= 1'b0;
      cpuMemRd      <= 1'b0;
      cpuMemAddr    <= '0;
      cpuMemWrData  <= '0;
      timeoutCnt    <= '0;
    end else begin
      // The gap counter runs in every state; a load below overrides it.
      if (gapCnt != '0) gapCnt <= gapCnt - GapWidth'(1);
      case (state)
        IDLE: begin
          if (hostReqValid && hostReqReady) begin
            cpuMemReq    <= 1'b1;
            cpuMemRd     <= hostReqRd;
            cpuMemAddr   <= hostReqAddr;
            cpuMemWrData <= hostReqWrData;
            waitTimer    <= '0;
            state        <= REQ;
          end
        end
        REQ: begin
          waitTimer <= waitTimer + TimerWidth'(1);
          // Ack takes priority over a timeout landing in the same cycle.
          if (cpuMemAck) begin
            cpuMemReq     <= 1'b0;
            hostRspRdData <= cpuMemRd ? cpuMemRdData : '0;
            hostRspErr    <= 1'b0;
            hostRspValid  <= 1'b1;
            gapCnt        <= GapLoad;
            state         <= RSP;
          end else if (waitTimer == TimerLast) begin
            cpuMemReq     <= 1'b0;
            hostRspRdData <= {DATA_WIDTH{ERR_DATA_ONES}};
            hostRspErr    <= 1'b1;
            hostRspValid  <= 1'b1;
            gapCnt        <= GapLoad;
            if (timeoutCnt != 8'hFF) timeoutCnt <= timeoutCnt + 8'd1;
            state         <= RSP;
          end
        end
        RSP: begin
          if (hostRspReady) begin
            hostRspValid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_cpu_mem_bridge.sv
// tb/tb_ip_cpu_mem_bridge.sv - self-checking bench for ip_cpu_mem_bridge
module tb_ip_cpu_mem_bridge;

  localparam int TO  = 8;
  localparam int GAP = 2;

  logic        clockCore = 1'b0;
  logic        resetCore = 1'b0;
  logic        hostReqValid = 1'b0;
  logic        hostReqReady;
  logic        hostReqRd = 1'b0;
  logic [7:0]  hostReqAddr = '0;
  logic [15:0] hostReqWrData = '0;
  logic        hostRspValid;
  logic        hostRspReady = 1'b0;
  logic [15:0] hostRspRdData;
  logic        hostRspErr;
  logic        cpuMemReq;
  logic        cpuMemRd;
  logic [7:0]  cpuMemAddr;
  logic [15:0] cpuMemWrData;
  logic        cpuMemAck = 1'b0;
  logic [15:0] cpuMemRdData = '0;
  logic [7:0]  timeoutCnt;

  int cmpCount = 0;
  int errCount = 0;
  int expTimeouts = 0;

  ip_cpu_mem_bridge #(
    .ADDR_WIDTH(8), .DATA_WIDTH(16), .TIMEOUT(TO), .GAP_CYCLES(GAP)
  ) dut (
    .clockCore(clockCore), .resetCore(resetCore),
    .hostReqValid(hostReqValid), .hostReqReady(hostReqReady), .hostReqRd(hostReqRd),
    .hostReqAddr(hostReqAddr), .hostReqWrData(hostReqWrData),
    .hostRspValid(hostRspValid), .hostRspReady(hostRspReady),
    .hostRspRdData(hostRspRdData), .hostRspErr(hostRspErr),
    .cpuMemReq(cpuMemReq), .cpuMemRd(cpuMemRd), .cpuMemAddr(cpuMemAddr),
    .cpuMemWrData(cpuMemWrData), .cpuMemAck(cpuMemAck), .cpuMemRdData(cpuMemRdData),
    .timeoutCnt(timeoutCnt)
  );

  always #5 clockCore = ~clockCore;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmpCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request-low run length before every rising edge of cpuMemReq.
  int  lowRun  = 0;
  bit  sawFall = 0;
  logic prevReq = 1'b0;
  always @(negedge clockCore) begin
    if (cpuMemReq && !prevReq && sawFall) checkEq("reqGap", 32'(lowRun >= GAP), 1);
    if (!cpuMemReq && prevReq) sawFall = 1;
    lowRun  = cpuMemReq ? 0 : lowRun + 1;
    prevReq = cpuMemReq;
  end

  // One host access. ackAt = cycles after cpuMemReq rises when the memory
  // model pulses ack (negative = never). Called and returns at a negedge.
  task automatic runAccess(input logic rd, input logic [7:0] addr, input logic [15:0] wd,
                           input int ackAt, input logic [15:0] rdat, input int rspDelay,
                           input bit keepValid);
    int expHigh, cyc, high, phase, hold;
    bit timedOut;
    logic [15:0] expData;
    timedOut = (ackAt < 0) || (ackAt > TO - 1);
    expHigh  = timedOut ? TO : ackAt + 1;
    expData  = timedOut ? 16'hFFFF : (rd ? rdat : 16'h0000);
    hostReqRd = rd; hostReqAddr = addr; hostReqWrData = wd; hostReqValid = 1'b1;
    for (int i = 0; i < 100 && !hostReqReady; i++) @(negedge clockCore);
    if (!hostReqReady) begin
      checkEq("acceptBound", 0, 1);
      hostReqValid = 1'b0;
      return;
    end
    @(negedge clockCore);
    if (!keepValid) hostReqValid = 1'b0;
    cyc = 0; high = 0; phase = 0; hold = 0;
    while (phase != 2 && cyc < 200) begin
      if (phase == 1 && hostRspReady) begin
        checkEq("rspDrop", hostRspValid, 0);
        hostRspReady = 1'b0;
        cpuMemAck = 1'b0;
        phase = 2;
      end else if (phase == 0 && cpuMemReq) begin
        high++;
        checkEq("reqRd", cpuMemRd, rd);
        checkEq("reqAddr", cpuMemAddr, addr);
        checkEq("reqWrData", cpuMemWrData, wd);
        checkEq("rspEarly", hostRspValid, 0);
        checkEq("readyBusy", hostReqReady, 0);
      end else begin
        if (phase == 0) begin
          phase = 1;
          checkEq("reqHigh", high, expHigh);
        end
        checkEq("rspValid", hostRspValid, 1);
        checkEq("rspData", hostRspRdData, expData);
        checkEq("rspErr", hostRspErr, timedOut);
        checkEq("readyRsp", hostReqReady, 0);
        if (hold >= rspDelay && (ackAt < 0 || cyc >= ackAt)) hostRspReady = 1'b1;
        hold++;
      end
      if (phase != 2) begin
        cpuMemAck    = (cyc == ackAt);
        cpuMemRdData = (cyc == ackAt) ? rdat : 16'($urandom);
        cyc++;
        @(negedge clockCore);
      end
    end
    if (phase != 2) checkEq("rspBound", 0, 1);
    if (timedOut && expTimeouts < 255) expTimeouts++;
    checkEq("timeoutCnt", timeoutCnt, expTimeouts);
  endtask

  initial begin
    repeat (3) @(negedge clockCore);
    checkEq("rstReady", hostReqReady, 1);
    checkEq("rstRspValid", hostRspValid, 0);
    checkEq("rstReq", cpuMemReq, 0);
    checkEq("rstRd", cpuMemRd, 0);
    checkEq("rstAddr", cpuMemAddr, 0);
    checkEq("rstWrData", cpuMemWrData, 0);
    checkEq("rstRdData", hostRspRdData, 0);
    checkEq("rstErr", hostRspErr, 0);
    checkEq("rstTimeouts", timeoutCnt, 0);
    resetCore = 1'b1;
    @(negedge clockCore);

    runAccess(1'b1, 8'h12, 16'h0000, 2, 16'hBEEF, 0, 1'b0);
    runAccess(1'b0, 8'h01, 16'h1111, 0, 16'h9999, 0, 1'b1);
    runAccess(1'b0, 8'h02, 16'h2222, 0, 16'h9999, 0, 1'b0);
    runAccess(1'b1, 8'h55, 16'h0000, -1, 16'h0000, 0, 1'b0);
    runAccess(1'b1, 8'h20, 16'h0000, 10, 16'h1234, 0, 1'b0);
    checkEq("lateAckNoRsp", hostRspValid, 0);
    runAccess(1'b1, 8'h21, 16'h0000, 2, 16'h5A5A, 0, 1'b0);
    runAccess(1'b1, 8'h33, 16'h0000, 1, 16'hCAFE, 5, 1'b0);
    runAccess(1'b1, 8'h44, 16'h0000, TO - 1, 16'h7777, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      int ackAt;
      ackAt = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 11));
      runAccess(1'($urandom), 8'($urandom), 16'($urandom), ackAt, 16'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom));
    end
    hostReqValid = 1'b0;

    // Reset in the middle of an access.
    repeat (3) @(negedge clockCore);
    hostReqRd = 1'b1; hostReqAddr = 8'h66; hostReqValid = 1'b1;
    for (int i = 0; i < 20 && !hostReqReady; i++) @(negedge clockCore);
    @(negedge clockCore);
    hostReqValid = 1'b0;
    checkEq("rstMidReqUp", cpuMemReq, 1);
    @(negedge clockCore);
    #2 resetCore = 1'b0;
    #1;
    checkEq("rstMidReq", cpuMemReq, 0);
    checkEq("rstMidRsp", hostRspValid, 0);
    checkEq("rstMidTimeouts", timeoutCnt, 0);
    expTimeouts = 0;
    repeat (2) @(negedge clockCore);
    resetCore = 1'b1;
    repeat (3) begin
      @(negedge clockCore);
      checkEq("rstNoRsp", hostRspValid, 0);
    end
    runAccess(1'b1, 8'h67, 16'h0000, 3, 16'hA5C3, 1, 1'b0);
    runAccess(1'b0, 8'h68, 16'h4242, 0, 16'h1111, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
